// File: rtl/shift_tx_pkg.sv
// Shared types for the serial shift-channel scheduler.
package shift_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef logic req_idx_t;

endpackage

// File: rtl/shift_tx_sched_if.sv
// Requester handshakes and serial output of the shift-channel scheduler.
interface shift_tx_sched_if #(
    parameter int WIDTH = 8
);
    import shift_tx_pkg::*;

    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             s_out;
    logic             frame;
    req_idx_t         grant_id;
    logic             done;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, s_out, frame, grant_id, done
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, s_out, frame, grant_id, done
    );

endinterface

// File: rtl/shift_tx_sched_piso_shifter.sv
// Parallel-in/serial-out shifter; q is registered and presents the first bit
// in the cycle after load. Zero fill makes q fall to 0 after the last bit.
module piso_shifter #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (clear) begin
            sr <= '0;
            q  <= 1'b0;
        end else if (load) begin
            if (LSB_FIRST) begin
                q  <= d[0];
                sr <= d >> 1;
            end else begin
                q  <= d[WIDTH-1];
                sr <= d << 1;
            end
        end else if (shift) begin
            if (LSB_FIRST) begin
                q  <= sr[0];
                sr <= sr >> 1;
            end else begin
                q  <= sr[WIDTH-1];
                sr <= sr << 1;
            end
        end
    end

endmodule

// File: rtl/shift_tx_sched.sv
// Round-robin scheduler sharing one serial shift channel between two
// word requesters: IDLE accepts a word, SHIFT emits WIDTH bits, GAP pulses done.
module shift_tx_sched
    import shift_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic clear,
    shift_tx_sched_if.slave bus
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    req_idx_t      last, pick;
    logic          take, shift_en;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        pick = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            pick = ~last;
        end else if (bus.req1_valid) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        take           = 1'b0;
        shift_en       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!clear && (bus.req0_valid || bus.req1_valid)) begin
                    take           = 1'b1;
                    bus.req0_ready = (pick == 1'b0);
                    bus.req1_ready = (pick == 1'b1);
                    state_nxt      = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST_BIT) begin
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            cnt          <= '0;
            last         <= 1'b1;
            bus.grant_id <= 1'b0;
            bus.frame    <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus.frame <= (state_nxt == SHIFT);
            bus.done  <= (state_nxt == GAP);
            if (take) begin
                cnt          <= '0;
                last         <= pick;
                bus.grant_id <= pick;
            end else if (state == SHIFT && cnt != LAST_BIT) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    piso_shifter #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .clear (clear),
        .load  (take),
        .shift (shift_en),
        .d     ((pick == 1'b1) ? bus.req1_data : bus.req0_data),
        .q     (bus.s_out)
    );

endmodule

// File: tb/tb_shift_tx_sched.sv
// Directed bench for shift_tx_sched: one LSB-first and one MSB-first instance.
module tb_shift_tx_sched;
    import shift_tx_pkg::*;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    shift_tx_sched_if #(.WIDTH(8)) bus_a ();
    shift_tx_sched_if #(.WIDTH(8)) bus_b ();

    shift_tx_sched #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
        .clk (clk), .clear (clear), .bus (bus_a.slave)
    );
    shift_tx_sched #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clk (clk), .clear (clear), .bus (bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_a  = 0;
    int done_b  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.done) done_a <= done_a + 1;
        if (bus_b.done) done_b <= done_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle T+1 after a handshake edge; returns in the first IDLE cycle.
    task automatic expect_frame(input bit on_b, input logic [7:0] w, input bit lsb,
                                input logic gid, input string tag);
        logic eb;
        chk({tag, ".grant"}, on_b ? bus_b.grant_id : bus_a.grant_id, gid);
        for (int k = 0; k < 8; k++) begin
            eb = lsb ? w[k] : w[7-k];
            chk($sformatf("%s.bit%0d", tag, k), on_b ? bus_b.s_out : bus_a.s_out, eb);
            chk($sformatf("%s.frame%0d", tag, k), on_b ? bus_b.frame : bus_a.frame, 1'b1);
            chk($sformatf("%s.nodone%0d", tag, k), on_b ? bus_b.done : bus_a.done, 1'b0);
            chk($sformatf("%s.rdy_shift%0d", tag, k),
                on_b ? {bus_b.req0_ready, bus_b.req1_ready} : {bus_a.req0_ready, bus_a.req1_ready}, 2'b00);
            tick();
        end
        chk({tag, ".gap_frame"}, on_b ? bus_b.frame : bus_a.frame, 1'b0);
        chk({tag, ".gap_sout"}, on_b ? bus_b.s_out : bus_a.s_out, 1'b0);
        chk({tag, ".gap_done"}, on_b ? bus_b.done : bus_a.done, 1'b1);
        chk({tag, ".rdy_gap"},
            on_b ? {bus_b.req0_ready, bus_b.req1_ready} : {bus_a.req0_ready, bus_a.req1_ready}, 2'b00);
        tick();
        chk({tag, ".done_low"}, on_b ? bus_b.done : bus_a.done, 1'b0);
    endtask

    int hs[4];
    int dbase;
    logic g;

    initial begin
        clear = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req1_valid = 1'b1;
        bus_a.req0_data  = 8'h00; bus_a.req1_data  = 8'h00;
        bus_b.req0_valid = 1'b0; bus_b.req1_valid = 1'b0;
        bus_b.req0_data  = 8'h00; bus_b.req1_data  = 8'h00;
        tick();
        tick();
        chk("rst.ready", {bus_a.req0_ready, bus_a.req1_ready}, 2'b00);
        chk("rst.sout", bus_a.s_out, 1'b0);
        chk("rst.frame", bus_a.frame, 1'b0);
        chk("rst.done", bus_a.done, 1'b0);
        chk("rst.grant", bus_a.grant_id, 1'b0);
        clear = 1'b0;
        bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
        tick();
        chk("idle.frame", bus_a.frame, 1'b0);

        // Single word, LSB first
        bus_a.req0_data = 8'hA5; bus_a.req0_valid = 1'b1;
        #1;
        chk("a5.ready", {bus_a.req0_ready, bus_a.req1_ready}, 2'b10);
        tick();
        bus_a.req0_valid = 1'b0;
        expect_frame(1'b0, 8'hA5, 1'b1, 1'b0, "a5");
        chk("a5.done_cnt", done_a, 1);

        // MSB first instance
        bus_b.req1_data = 8'h81; bus_b.req1_valid = 1'b1;
        #1;
        chk("b81.ready", {bus_b.req0_ready, bus_b.req1_ready}, 2'b01);
        tick();
        bus_b.req1_valid = 1'b0;
        expect_frame(1'b1, 8'h81, 1'b0, 1'b1, "b81");
        bus_b.req0_data = 8'hC2; bus_b.req0_valid = 1'b1;
        #1;
        chk("bc2.ready", {bus_b.req0_ready, bus_b.req1_ready}, 2'b10);
        tick();
        bus_b.req0_valid = 1'b0;
        expect_frame(1'b1, 8'hC2, 1'b0, 1'b0, "bc2");
        chk("b.done_cnt", done_b, 2);

        // Both held: alternate grants, one handshake every 10 cycles
        clear = 1'b1;
        tick();
        clear = 1'b0;
        dbase = done_a;
        bus_a.req0_data = 8'h0F; bus_a.req1_data = 8'hF0;
        bus_a.req0_valid = 1'b1; bus_a.req1_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            g = (f % 2 == 1);
            #1;
            chk($sformatf("rr%0d.ready", f), {bus_a.req0_ready, bus_a.req1_ready}, g ? 2'b01 : 2'b10);
            tick();
            hs[f] = cyc;
            expect_frame(1'b0, g ? 8'hF0 : 8'h0F, 1'b1, g, $sformatf("rr%0d", f));
        end
        bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
        for (int f = 1; f < 4; f++) chk($sformatf("rr.spacing%0d", f), hs[f] - hs[f-1], 10);
        chk("rr.done_cnt", done_a - dbase, 4);
        tick();

        // Clear in the 4th SHIFT cycle aborts the frame without done
        bus_a.req0_data = 8'hFF; bus_a.req0_valid = 1'b1;
        tick();
        bus_a.req0_valid = 1'b0;
        tick(); tick(); tick();
        chk("abort.sout_before", bus_a.s_out, 1'b1);
        clear = 1'b1;
        bus_a.req0_valid = 1'b1; bus_a.req1_valid = 1'b1;
        dbase = done_a;
        tick();
        chk("abort.frame", bus_a.frame, 1'b0);
        chk("abort.sout", bus_a.s_out, 1'b0);
        chk("abort.done", bus_a.done, 1'b0);
        chk("abort.ready_in_clear", {bus_a.req0_ready, bus_a.req1_ready}, 2'b00);
        clear = 1'b0;
        bus_a.req0_data = 8'h0F;
        #1;
        chk("abort.ready_after", {bus_a.req0_ready, bus_a.req1_ready}, 2'b10);
        tick();
        bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
        expect_frame(1'b0, 8'h0F, 1'b1, 1'b0, "post_clr");
        chk("abort.done_cnt", done_a - dbase, 1);

        // req0 pulsed only during SHIFT is never accepted
        bus_a.req1_data = 8'h3C; bus_a.req1_valid = 1'b1;
        #1;
        chk("pulse.ready1", {bus_a.req0_ready, bus_a.req1_ready}, 2'b01);
        tick();
        bus_a.req1_valid = 1'b0;
        bus_a.req0_data = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) bus_a.req0_valid = 1'b1;
            if (k == 5) bus_a.req0_valid = 1'b0;
            #1;
            if (k >= 2 && k < 5) chk($sformatf("pulse.ready0_%0d", k), bus_a.req0_ready, 1'b0);
            chk($sformatf("pulse.bit%0d", k), bus_a.s_out, (8'h3C >> k) & 8'h01);
            tick();
        end
        chk("pulse.gap_done", bus_a.done, 1'b1);
        tick();
        chk("pulse.idle_frame", bus_a.frame, 1'b0);
        tick();
        chk("pulse.not_captured", bus_a.frame, 1'b0);
        chk("pulse.grant_kept", bus_a.grant_id, 1'b1);
        bus_a.req0_valid = 1'b1;
        #1;
        chk("pulse.held_ready", {bus_a.req0_ready, bus_a.req1_ready}, 2'b10);
        tick();
        bus_a.req0_valid = 1'b0;
        expect_frame(1'b0, 8'h5A, 1'b1, 1'b0, "held");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
